// File: rtl/dbg_pkg.sv
// Shared encodings for the ifetch debug halt/step controller.
package dbg_pkg;

   localparam int PC_W   = 11;
   localparam int STEP_W = 8;

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_HALT = 2'b01,
      ST_STEP = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_BKPT = 2'b01,
      CAUSE_EXT  = 2'b10,
      CAUSE_STEP = 2'b11
   } cause_e;

endpackage

// File: rtl/dbg_step_cnt.sv
// Remaining-instruction counter for debug single-stepping.
module dbg_step_cnt #(
   parameter int STEP_W = dbg_pkg::STEP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [STEP_W-1:0] load_val,
   input  logic              dec,
   input  logic              clr,
   output logic              last
);

   logic [STEP_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         // A requested count of zero still steps one instruction.
         cnt_d = (load_val == '0) ? STEP_W'(1) : load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - STEP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == STEP_W'(1));

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug halt/step controller: drives the fetch lock and records halt cause and PC.
module dbg_halt_ctrl #(
   parameter int PC_W   = dbg_pkg::PC_W,
   parameter int STEP_W = dbg_pkg::STEP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              timer_done,
   input  logic [PC_W-1:0]   mv_PC,
   input  logic              inst_adv,
   input  logic              ext_halt_req,
   input  logic              ext_run_req,
   input  logic              ext_step_req,
   input  logic [STEP_W-1:0] ext_step_num,
   output logic              dbg_lock,
   output logic              halted,
   output logic              halt_evt,
   output logic [1:0]        halt_cause,
   output logic [PC_W-1:0]   halt_pc
);

   import dbg_pkg::*;

   state_e            state_q, state_d;
   cause_e            cause_q, cause_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              evt_q, evt_d;
   logic              lock_q, lock_d;
   logic              cnt_load, cnt_dec, cnt_clr, cnt_last;

   dbg_step_cnt #(.STEP_W(STEP_W)) u_step_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (ext_step_num),
      .dec      (cnt_dec),
      .clr      (cnt_clr),
      .last     (cnt_last)
   );

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      pc_d     = pc_q;
      evt_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (timer_done || ext_halt_req) begin
               state_d = ST_HALT;
               cause_d = timer_done ? CAUSE_BKPT : CAUSE_EXT;
               pc_d    = mv_PC;
               evt_d   = 1'b1;
            end
         end
         ST_HALT: begin
            if (ext_run_req) begin
               state_d = ST_RUN;
            end else if (ext_step_req) begin
               state_d  = ST_STEP;
               cnt_load = 1'b1;
            end
         end
         ST_STEP: begin
            // Any exit from STEP discards whatever count remains.
            if (timer_done || ext_halt_req || (inst_adv && cnt_last)) begin
               state_d = ST_HALT;
               cause_d = timer_done ? CAUSE_BKPT : (ext_halt_req ? CAUSE_EXT : CAUSE_STEP);
               pc_d    = mv_PC;
               evt_d   = 1'b1;
               cnt_clr = 1'b1;
            end else if (ext_run_req) begin
               state_d = ST_RUN;
               cnt_clr = 1'b1;
            end else begin
               cnt_dec = inst_adv;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
         end
      endcase
      lock_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         cause_q <= CAUSE_NONE;
         pc_q    <= '0;
         evt_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         evt_q   <= evt_d;
         lock_q  <= lock_d;
      end
   end

   assign dbg_lock   = lock_q;
   assign halted     = lock_q;
   assign halt_evt   = evt_q;
   assign halt_cause = cause_q;
   assign halt_pc    = pc_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Directed bench for dbg_halt_ctrl with hand-computed expectations.
module tb_dbg_halt_ctrl;

   localparam int PC_W   = 11;
   localparam int STEP_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              timer_done;
   logic [PC_W-1:0]   mv_PC;
   logic              inst_adv;
   logic              ext_halt_req;
   logic              ext_run_req;
   logic              ext_step_req;
   logic [STEP_W-1:0] ext_step_num;
   logic              dbg_lock;
   logic              halted;
   logic              halt_evt;
   logic [1:0]        halt_cause;
   logic [PC_W-1:0]   halt_pc;

   int n_chk  = 0;
   int n_pass = 0;

   dbg_halt_ctrl #(.PC_W(PC_W), .STEP_W(STEP_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .timer_done   (timer_done),
      .mv_PC        (mv_PC),
      .inst_adv     (inst_adv),
      .ext_halt_req (ext_halt_req),
      .ext_run_req  (ext_run_req),
      .ext_step_req (ext_step_req),
      .ext_step_num (ext_step_num),
      .dbg_lock     (dbg_lock),
      .halted       (halted),
      .halt_evt     (halt_evt),
      .halt_cause   (halt_cause),
      .halt_pc      (halt_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock edge; inputs are then changed and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cmds();
      timer_done   = 1'b0;
      inst_adv     = 1'b0;
      ext_halt_req = 1'b0;
      ext_run_req  = 1'b0;
      ext_step_req = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic lock, input logic evt,
                            input logic [1:0] cause, input logic [PC_W-1:0] pc);
      check({tag, ".lock"},   32'(dbg_lock),   32'(lock));
      check({tag, ".halted"}, 32'(halted),     32'(lock));
      check({tag, ".evt"},    32'(halt_evt),   32'(evt));
      check({tag, ".cause"},  32'(halt_cause), 32'(cause));
      check({tag, ".pc"},     32'(halt_pc),    32'(pc));
   endtask

   initial begin
      clear_cmds();
      mv_PC        = '0;
      ext_step_num = '0;
      reset        = 1'b1;
      tick();
      check_all("rst", 1'b0, 1'b0, 2'b00, 11'h000);
      tick();
      reset = 1'b0;
      tick();

      // Breakpoint halt, hold in HALT, resume
      mv_PC = 11'h1A3; timer_done = 1'b1;
      tick(); clear_cmds(); mv_PC = 11'h1FF;
      check_all("bkpt", 1'b1, 1'b1, 2'b01, 11'h1A3);
      tick();
      check_all("bkpt_hold", 1'b1, 1'b0, 2'b01, 11'h1A3);
      timer_done = 1'b1; ext_halt_req = 1'b1; inst_adv = 1'b1;
      tick(); clear_cmds();
      check_all("halt_ignore", 1'b1, 1'b0, 2'b01, 11'h1A3);
      ext_run_req = 1'b1;
      tick(); clear_cmds();
      check_all("resume", 1'b0, 1'b0, 2'b01, 11'h1A3);

      // Breakpoint beats external halt; run beats step
      mv_PC = 11'h055; timer_done = 1'b1; ext_halt_req = 1'b1;
      tick(); clear_cmds();
      check_all("simul", 1'b1, 1'b1, 2'b01, 11'h055);
      ext_step_num = 8'd1; ext_run_req = 1'b1; ext_step_req = 1'b1;
      tick(); clear_cmds();
      check("run_over_step.lock", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1; mv_PC = 11'h066;
      tick(); clear_cmds();
      check_all("run_inst_ign", 1'b0, 1'b0, 2'b01, 11'h055);

      // External halt from RUN
      mv_PC = 11'h0AA; ext_halt_req = 1'b1;
      tick(); clear_cmds();
      check_all("ext", 1'b1, 1'b1, 2'b10, 11'h0AA);

      // Step 3 with inst_adv at cycles 2, 4, 5
      ext_step_num = 8'd3; ext_step_req = 1'b1;
      tick(); clear_cmds();
      check("s3.c1", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1;
      tick(); clear_cmds();
      check("s3.c2", 32'(dbg_lock), 32'd0);
      tick();
      check("s3.c3", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1;
      tick(); clear_cmds();
      check("s3.c4", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1; mv_PC = 11'h010;
      tick(); clear_cmds(); mv_PC = 11'h011;
      check_all("s3.done", 1'b1, 1'b1, 2'b11, 11'h010);
      tick();
      check("s3.evt_off", 32'(halt_evt), 32'd0);

      // Step count of zero steps exactly one instruction
      ext_step_num = 8'd0; ext_step_req = 1'b1;
      tick(); clear_cmds();
      check("s0.run", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1; mv_PC = 11'h020;
      tick(); clear_cmds();
      check_all("s0.done", 1'b1, 1'b1, 2'b11, 11'h020);

      // Breakpoint during a 4-step; leftover count must not leak into next step
      ext_step_num = 8'd4; ext_step_req = 1'b1;
      tick(); clear_cmds();
      inst_adv = 1'b1;
      tick(); clear_cmds();
      mv_PC = 11'h030; timer_done = 1'b1; inst_adv = 1'b1;
      tick(); clear_cmds();
      check_all("s4.bkpt", 1'b1, 1'b1, 2'b01, 11'h030);
      ext_step_num = 8'd1; ext_step_req = 1'b1;
      tick(); clear_cmds();
      check("s1.run", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1; mv_PC = 11'h031;
      tick(); clear_cmds();
      check_all("s1.done", 1'b1, 1'b1, 2'b11, 11'h031);

      // External halt in STEP with two left; next step reloads from ext_step_num
      ext_step_num = 8'd3; ext_step_req = 1'b1;
      tick(); clear_cmds();
      inst_adv = 1'b1;
      tick(); clear_cmds();
      mv_PC = 11'h040; ext_halt_req = 1'b1;
      tick(); clear_cmds();
      check_all("sx.ext", 1'b1, 1'b1, 2'b10, 11'h040);
      ext_step_num = 8'd2; ext_step_req = 1'b1;
      tick(); clear_cmds();
      inst_adv = 1'b1;
      tick(); clear_cmds();
      check("sx.reload1", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1; mv_PC = 11'h042;
      tick(); clear_cmds();
      check_all("sx.reload2", 1'b1, 1'b1, 2'b11, 11'h042);

      // Held step request re-enters STEP after each completion
      ext_step_num = 8'd1; ext_step_req = 1'b1;
      tick();
      check("lvl.step1", 32'(dbg_lock), 32'd0);
      inst_adv = 1'b1; mv_PC = 11'h050;
      tick(); inst_adv = 1'b0;
      check_all("lvl.halt1", 1'b1, 1'b1, 2'b11, 11'h050);
      tick();
      check("lvl.step2", 32'(dbg_lock), 32'd0);
      ext_step_req = 1'b0; inst_adv = 1'b1; mv_PC = 11'h051;
      tick(); clear_cmds();
      check_all("lvl.halt2", 1'b1, 1'b1, 2'b11, 11'h051);

      // Asynchronous reset mid-step with five steps outstanding
      ext_step_num = 8'd5; ext_step_req = 1'b1;
      tick(); clear_cmds();
      inst_adv = 1'b1;
      tick(); clear_cmds();
      #2 reset = 1'b1;
      #1;
      check_all("rst_step", 1'b0, 1'b0, 2'b00, 11'h000);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         inst_adv = 1'b1; mv_PC = 11'h060;
         tick();
      end
      clear_cmds();
      check_all("rst_after", 1'b0, 1'b0, 2'b00, 11'h000);

      // Asynchronous reset while halted
      mv_PC = 11'h070; ext_halt_req = 1'b1;
      tick(); clear_cmds();
      check("pre_rst_halt.lock", 32'(dbg_lock), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_all("rst_halt", 1'b0, 1'b0, 2'b00, 11'h000);
      tick();
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
